// File: rtl/axi_common_types_pkg.sv
// Shared AXI types for the NoC slave ports: ID/address widths, burst and
// response encodings, and the write/read FSM state enums.
package axi_common_types_pkg;

    localparam int AXI_SID_WIDTH  = 4;
    localparam int AXI_ADDR_WIDTH = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/s2_axi_mem_slave_if.sv
// AXI4 channel bundle for NoC slave port S2 (no LOCK/CACHE/PROT/QOS/REGION/USER
// on the request side; BUSER/RUSER present but driven low by the slave).
interface s2_axi_mem_slave_if
    import axi_common_types_pkg::*;
#(
    parameter int SID_W  = AXI_SID_WIDTH,
    parameter int ADDR_W = AXI_ADDR_WIDTH,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [SID_W-1:0]  S2_AWID;
    logic [ADDR_W-1:0] S2_AWADDR;
    logic [3:0]        S2_AWLEN;
    logic [2:0]        S2_AWSIZE;
    logic [1:0]        S2_AWBURST;
    logic              S2_AWVALID;
    logic              S2_AWREADY;

    logic [DATA_W-1:0] S2_WDATA;
    logic [STRB_W-1:0] S2_WSTRB;
    logic              S2_WLAST;
    logic              S2_WVALID;
    logic              S2_WREADY;

    logic [SID_W-1:0]  S2_BID;
    logic [1:0]        S2_BRESP;
    logic              S2_BUSER;
    logic              S2_BVALID;
    logic              S2_BREADY;

    logic [SID_W-1:0]  S2_ARID;
    logic [ADDR_W-1:0] S2_ARADDR;
    logic [3:0]        S2_ARLEN;
    logic [2:0]        S2_ARSIZE;
    logic [1:0]        S2_ARBURST;
    logic              S2_ARVALID;
    logic              S2_ARREADY;

    logic [SID_W-1:0]  S2_RID;
    logic [DATA_W-1:0] S2_RDATA;
    logic [1:0]        S2_RRESP;
    logic              S2_RLAST;
    logic              S2_RUSER;
    logic              S2_RVALID;
    logic              S2_RREADY;

    modport slave (
        input  S2_AWID, S2_AWADDR, S2_AWLEN, S2_AWSIZE, S2_AWBURST, S2_AWVALID,
        output S2_AWREADY,
        input  S2_WDATA, S2_WSTRB, S2_WLAST, S2_WVALID,
        output S2_WREADY,
        output S2_BID, S2_BRESP, S2_BUSER, S2_BVALID,
        input  S2_BREADY,
        input  S2_ARID, S2_ARADDR, S2_ARLEN, S2_ARSIZE, S2_ARBURST, S2_ARVALID,
        output S2_ARREADY,
        output S2_RID, S2_RDATA, S2_RRESP, S2_RLAST, S2_RUSER, S2_RVALID,
        input  S2_RREADY
    );

    modport master (
        output S2_AWID, S2_AWADDR, S2_AWLEN, S2_AWSIZE, S2_AWBURST, S2_AWVALID,
        input  S2_AWREADY,
        output S2_WDATA, S2_WSTRB, S2_WLAST, S2_WVALID,
        input  S2_WREADY,
        input  S2_BID, S2_BRESP, S2_BUSER, S2_BVALID,
        output S2_BREADY,
        output S2_ARID, S2_ARADDR, S2_ARLEN, S2_ARSIZE, S2_ARBURST, S2_ARVALID,
        input  S2_ARREADY,
        input  S2_RID, S2_RDATA, S2_RRESP, S2_RLAST, S2_RUSER, S2_RVALID,
        output S2_RREADY
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst helper: next beat address, word index into the
// local array, and the per-beat SLVERR decision (range and illegal burst).
module axi_burst_addr_gen
    import axi_common_types_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                STRB_W    = 4,
    parameter int                MEM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic [ADDR_W-1:0]            addr,
    input  logic [3:0]                   len,
    input  logic [2:0]                   size,
    input  logic [1:0]                   burst,
    output logic [ADDR_W-1:0]            next_addr,
    output logic [$clog2(MEM_DEPTH)-1:0] word_idx,
    output logic                         beat_err
);
    localparam int                OFF_W = $clog2(STRB_W);
    localparam int                IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(MEM_DEPTH * STRB_W);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] rel;
    logic              in_range;
    logic              wrap_len_ok;
    logic              burst_bad;

    always_comb begin
        step        = ADDR_W'(1) << size;
        // WRAP window is (LEN+1)*step bytes; only legal when that is a power of two
        wrap_mask   = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        rel         = addr - BASE_ADDR;
        in_range    = (addr >= BASE_ADDR) && (rel < SPAN);
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        burst_bad   = (burst == 2'b11)
                    || (size > 3'(OFF_W))
                    || ((burst == BURST_WRAP) && !wrap_len_ok);
        beat_err    = !in_range || burst_bad;
        word_idx    = rel[OFF_W +: IDX_W];

        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = addr + step;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:     next_addr = addr + step;
        endcase
    end

endmodule

// File: rtl/s2_axi_mem_slave.sv
// AXI4 slave memory terminating NoC port S2: independent write and read FSMs,
// one burst outstanding each, backed by a byte-writable flop array.
module s2_axi_mem_slave
    import axi_common_types_pkg::*;
#(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0002_0000
) (
    input logic              ACLK,
    input logic              ARESETn,
    s2_axi_mem_slave_if.slave s2
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_e                  w_state;
    logic [AXI_ADDR_WIDTH-1:0] w_addr;
    logic [3:0]                w_len;
    logic [2:0]                w_size;
    logic [1:0]                w_burst;
    logic [3:0]                w_beat;
    logic                      w_err;
    logic [AXI_ADDR_WIDTH-1:0] wg_next;
    logic [IDX_W-1:0]          wg_idx;
    logic                      wg_err;
    logic                      w_commit;

    r_state_e                  r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [3:0]                r_len;
    logic [2:0]                r_size;
    logic [1:0]                r_burst;
    logic [3:0]                r_beat;
    logic [AXI_ADDR_WIDTH-1:0] rg_addr;
    logic [3:0]                rg_len;
    logic [2:0]                rg_size;
    logic [1:0]                rg_burst;
    logic [AXI_ADDR_WIDTH-1:0] rg_next;
    logic [IDX_W-1:0]          rg_idx;
    logic                      rg_err;

    assign s2.S2_BUSER = 1'b0;
    assign s2.S2_RUSER = 1'b0;

    axi_burst_addr_gen #(
        .ADDR_W   (AXI_ADDR_WIDTH),
        .STRB_W   (STRB_W),
        .MEM_DEPTH(MEM_DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) u_wr_gen (
        .addr     (w_addr),
        .len      (w_len),
        .size     (w_size),
        .burst    (w_burst),
        .next_addr(wg_next),
        .word_idx (wg_idx),
        .beat_err (wg_err)
    );

    // In R_IDLE the generator looks at the incoming AR so beat 0 is fetched on the handshake
    always_comb begin
        if (r_state == R_IDLE) begin
            rg_addr  = s2.S2_ARADDR;
            rg_len   = s2.S2_ARLEN;
            rg_size  = s2.S2_ARSIZE;
            rg_burst = s2.S2_ARBURST;
        end else begin
            rg_addr  = r_addr;
            rg_len   = r_len;
            rg_size  = r_size;
            rg_burst = r_burst;
        end
    end

    axi_burst_addr_gen #(
        .ADDR_W   (AXI_ADDR_WIDTH),
        .STRB_W   (STRB_W),
        .MEM_DEPTH(MEM_DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) u_rd_gen (
        .addr     (rg_addr),
        .len      (rg_len),
        .size     (rg_size),
        .burst    (rg_burst),
        .next_addr(rg_next),
        .word_idx (rg_idx),
        .beat_err (rg_err)
    );

    assign w_commit = s2.S2_WVALID && s2.S2_WREADY && !wg_err;

    always_ff @(posedge ACLK) begin
        if (w_commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s2.S2_WSTRB[b]) begin
                    mem[wg_idx][8*b +: 8] <= s2.S2_WDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state       <= W_IDLE;
            w_addr        <= '0;
            w_len         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_beat        <= '0;
            w_err         <= 1'b0;
            s2.S2_AWREADY <= 1'b0;
            s2.S2_WREADY  <= 1'b0;
            s2.S2_BVALID  <= 1'b0;
            s2.S2_BID     <= '0;
            s2.S2_BRESP   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s2.S2_AWVALID && s2.S2_AWREADY) begin
                        w_addr        <= s2.S2_AWADDR;
                        w_len         <= s2.S2_AWLEN;
                        w_size        <= s2.S2_AWSIZE;
                        w_burst       <= s2.S2_AWBURST;
                        s2.S2_BID     <= s2.S2_AWID;
                        w_beat        <= '0;
                        w_err         <= 1'b0;
                        s2.S2_AWREADY <= 1'b0;
                        s2.S2_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end else begin
                        s2.S2_AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s2.S2_WVALID && s2.S2_WREADY) begin
                        w_addr <= wg_next;
                        w_beat <= w_beat + 4'd1;
                        // Beat count ends the burst; WLAST only feeds the error flag
                        if (w_beat == w_len) begin
                            s2.S2_WREADY <= 1'b0;
                            s2.S2_BVALID <= 1'b1;
                            s2.S2_BRESP  <= (w_err || wg_err || !s2.S2_WLAST) ? RESP_SLVERR
                                                                                : RESP_OKAY;
                            w_state      <= W_RESP;
                        end else begin
                            w_err <= w_err || wg_err || s2.S2_WLAST;
                        end
                    end
                end
                W_RESP: begin
                    if (s2.S2_BVALID && s2.S2_BREADY) begin
                        s2.S2_BVALID  <= 1'b0;
                        s2.S2_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // r_addr always holds the address of the next beat to fetch, not the one on the bus
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state       <= R_IDLE;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_beat        <= '0;
            s2.S2_ARREADY <= 1'b0;
            s2.S2_RVALID  <= 1'b0;
            s2.S2_RID     <= '0;
            s2.S2_RDATA   <= '0;
            s2.S2_RRESP   <= RESP_OKAY;
            s2.S2_RLAST   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s2.S2_ARVALID && s2.S2_ARREADY) begin
                        r_addr        <= rg_next;
                        r_len         <= s2.S2_ARLEN;
                        r_size        <= s2.S2_ARSIZE;
                        r_burst       <= s2.S2_ARBURST;
                        r_beat        <= '0;
                        s2.S2_RID     <= s2.S2_ARID;
                        s2.S2_RDATA   <= rg_err ? '0 : mem[rg_idx];
                        s2.S2_RRESP   <= rg_err ? RESP_SLVERR : RESP_OKAY;
                        s2.S2_RLAST   <= (s2.S2_ARLEN == 4'd0);
                        s2.S2_ARREADY <= 1'b0;
                        s2.S2_RVALID  <= 1'b1;
                        r_state       <= R_DATA;
                    end else begin
                        s2.S2_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s2.S2_RVALID && s2.S2_RREADY) begin
                        if (s2.S2_RLAST) begin
                            s2.S2_RVALID  <= 1'b0;
                            s2.S2_RLAST   <= 1'b0;
                            s2.S2_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_addr      <= rg_next;
                            r_beat      <= r_beat + 4'd1;
                            s2.S2_RDATA <= rg_err ? '0 : mem[rg_idx];
                            s2.S2_RRESP <= rg_err ? RESP_SLVERR : RESP_OKAY;
                            s2.S2_RLAST <= ((r_beat + 4'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
